// File: rtl/discr_pulse_gen_pkg.sv
// Shared definitions for the discriminator pulse generator.
//   state_t      : generator FSM state encoding
//   C_MIN_PERIOD : smallest period latched for a run, in bit periods
//   C_OUT_WIDTH  : bits per clock in the output word
package discr_pulse_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned C_MIN_PERIOD = 2;
  localparam int unsigned C_OUT_WIDTH  = 8;

endpackage

// File: rtl/discr_phase_chain.sv
// Combinational 8-lane phase/count walk for one output word.
// Lane 0 is earliest in time. Each lane advances the phase by one bit
// period; a pulse starts (count increments) whenever the phase is 0.
//   ph_in   : phase at lane 0 of this word
//   c_in    : pulses started before this word
//   per_q   : latched period (>= 2)
//   wid_q   : latched width (1 .. per_q-1)
//   n_q     : latched pulse count, 0 = continuous
//   word    : bitstream word, bit 0 earliest
//   ph_out  : phase for lane 0 of the next word
//   c_out   : pulses started up to the end of this word (saturating)
//   end_hit : the run ended somewhere within this word
module discr_phase_chain
  import discr_pulse_gen_pkg::*;
#(
  parameter int unsigned P_N_WIDTH = 32
) (
  input  logic [P_N_WIDTH-1:0]   ph_in,
  input  logic [P_N_WIDTH-1:0]   c_in,
  input  logic [P_N_WIDTH-1:0]   per_q,
  input  logic [P_N_WIDTH-1:0]   wid_q,
  input  logic [P_N_WIDTH-1:0]   n_q,
  output logic [C_OUT_WIDTH-1:0] word,
  output logic [P_N_WIDTH-1:0]   ph_out,
  output logic [P_N_WIDTH-1:0]   c_out,
  output logic                   end_hit
);

  localparam logic [P_N_WIDTH-1:0] ONE = P_N_WIDTH'(1);

  logic [P_N_WIDTH-1:0] ph;
  logic [P_N_WIDTH-1:0] c;
  logic                 ended;

  // Once the count is reached at a pulse boundary, the remaining lanes stay
  // low and the phase freezes, so the final pulse has always fully completed.
  always_comb begin
    ph    = ph_in;
    c     = c_in;
    ended = 1'b0;
    word  = '0;
    for (int unsigned k = 0; k < C_OUT_WIDTH; k++) begin
      if (!ended) begin
        if (ph == '0 && n_q != '0 && c == n_q) begin
          ended = 1'b1;
        end else begin
          if (ph == '0 && c != '1) begin
            c = c + ONE;
          end
          word[k] = (ph < wid_q);
          ph      = (ph + ONE == per_q) ? '0 : ph + ONE;
        end
      end
    end
    ph_out  = ph;
    c_out   = c;
    end_hit = ended;
  end

endmodule

// File: rtl/discr_pulse_gen.sv
// Discriminator-style pulse bitstream generator for in-firmware self-test.
// Emits P_OUT_WIDTH bits per clock (bit 0 earliest) containing pulses of
// programmable period, width and count, with a start/stop/done handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a run (ignored while busy, loses to stop)
//   stop          : abort the current run
//   pulse_period  : bit periods between rising edges (min 2)
//   pulse_width   : bit periods high per pulse (clamped to 1 .. period-1)
//   n_pulses      : pulses per run, 0 = continuous
//   bits_out      : registered bitstream word
//   busy          : run in progress
//   done          : one-cycle pulse on counted run completion
//   aborted       : one-cycle pulse when a run is stopped
//   n_sent        : pulses started in the current/last run (saturating)
module discr_pulse_gen
  import discr_pulse_gen_pkg::*;
#(
  parameter int unsigned P_N_WIDTH   = 32,
  parameter int unsigned P_OUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [P_N_WIDTH-1:0]   pulse_period,
  input  logic [P_N_WIDTH-1:0]   pulse_width,
  input  logic [P_N_WIDTH-1:0]   n_pulses,
  output logic [P_OUT_WIDTH-1:0] bits_out,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [P_N_WIDTH-1:0]   n_sent
);

  if (P_OUT_WIDTH != C_OUT_WIDTH) begin : g_bad_out_width
    $error("discr_pulse_gen: P_OUT_WIDTH must be 8");
  end

  localparam logic [P_N_WIDTH-1:0] ONE  = P_N_WIDTH'(1);
  localparam logic [P_N_WIDTH-1:0] MINP = P_N_WIDTH'(C_MIN_PERIOD);

  state_t               state;
  logic [P_N_WIDTH-1:0] per_q;
  logic [P_N_WIDTH-1:0] wid_q;
  logic [P_N_WIDTH-1:0] n_q;
  logic [P_N_WIDTH-1:0] phase;

  logic [P_N_WIDTH-1:0] per_next;
  logic [P_N_WIDTH-1:0] wid_max;
  logic [P_N_WIDTH-1:0] wid_next;

  logic [C_OUT_WIDTH-1:0] word;
  logic [P_N_WIDTH-1:0]   ph_out;
  logic [P_N_WIDTH-1:0]   c_out;
  logic                   end_hit;

  // Clamped configuration captured on the start edge.
  always_comb begin
    per_next = (pulse_period < MINP) ? MINP : pulse_period;
    wid_max  = per_next - ONE;
    if (pulse_width == '0) begin
      wid_next = ONE;
    end else if (pulse_width > wid_max) begin
      wid_next = wid_max;
    end else begin
      wid_next = pulse_width;
    end
  end

  discr_phase_chain #(
    .P_N_WIDTH(P_N_WIDTH)
  ) u_chain (
    .ph_in  (phase),
    .c_in   (n_sent),
    .per_q  (per_q),
    .wid_q  (wid_q),
    .n_q    (n_q),
    .word   (word),
    .ph_out (ph_out),
    .c_out  (c_out),
    .end_hit(end_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      per_q    <= MINP;
      wid_q    <= ONE;
      n_q      <= '0;
      phase    <= '0;
      bits_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      n_sent   <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          bits_out <= '0;
          if (start && !stop) begin
            per_q  <= per_next;
            wid_q  <= wid_next;
            n_q    <= n_pulses;
            phase  <= '0;
            n_sent <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            bits_out <= '0;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            bits_out <= P_OUT_WIDTH'(word);
            phase    <= ph_out;
            n_sent   <= c_out;
            if (end_hit) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_discr_pulse_gen.sv
module tb_discr_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] pulse_period;
  logic [31:0] pulse_width;
  logic [31:0] n_pulses;
  logic [7:0]  bits_out;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] n_sent;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  discr_pulse_gen #(
    .P_N_WIDTH  (32),
    .P_OUT_WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pulse_period(pulse_period),
    .pulse_width (pulse_width),
    .n_pulses    (n_pulses),
    .bits_out    (bits_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .n_sent      (n_sent)
  );

  typedef struct {
    string       name;
    logic        st;
    logic        sp;
    logic [31:0] per;
    logic [31:0] wid;
    logic [31:0] n;
    logic [7:0]  e_bits;
    logic        e_busy;
    logic        e_done;
    logic        e_ab;
    logic [31:0] e_nsent;
    int          e_edges;   // -1: no edge-count check on this row
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic st, logic sp, int per, int wid, int n,
                              logic [7:0] eb, logic ebz, logic ed, logic ea, int en, int ee);
    vec_t v;
    v.name = name; v.st = st; v.sp = sp;
    v.per = per; v.wid = wid; v.n = n;
    v.e_bits = eb; v.e_busy = ebz; v.e_done = ed; v.e_ab = ea;
    v.e_nsent = en; v.e_edges = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] eb, input logic ebz,
                       input logic ed, input logic ea, input logic [31:0] en);
    n_vec++;
    if (bits_out !== eb || busy !== ebz || done !== ed || aborted !== ea || n_sent !== en) begin
      n_bad++;
      $display("FAIL %s: got bits=%02h busy=%0b done=%0b aborted=%0b n_sent=%0d, want bits=%02h busy=%0b done=%0b aborted=%0b n_sent=%0d",
               name, bits_out, busy, done, aborted, n_sent, eb, ebz, ed, ea, en);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input int per, input int wid, input int n);
    start = st; stop = sp;
    pulse_period = per; pulse_width = wid; n_pulses = n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    logic prev;
    logic [7:0] w;
    logic [7:0] eb;

    // period 10, width 3, 4 pulses; config inputs scrambled after the latch
    vecs.push_back(mk("p10_start", 1, 0, 10, 3, 4, 8'h00, 1, 0, 0, 0, -1));
    vecs.push_back(mk("p10_w0",    0, 0,  2, 1, 0, 8'h07, 1, 0, 0, 1, -1));
    vecs.push_back(mk("p10_w1",    0, 0,  2, 1, 0, 8'h1C, 1, 0, 0, 2, -1));
    vecs.push_back(mk("p10_w2",    0, 0,  2, 1, 0, 8'h70, 1, 0, 0, 3, -1));
    vecs.push_back(mk("p10_w3",    0, 0,  2, 1, 0, 8'hC0, 1, 0, 0, 4, -1));
    vecs.push_back(mk("p10_w4",    0, 0,  2, 1, 0, 8'h01, 1, 0, 0, 4, -1));
    vecs.push_back(mk("p10_done",  0, 0,  2, 1, 0, 8'h00, 0, 1, 0, 4, -1));
    vecs.push_back(mk("p10_after", 0, 0,  2, 1, 0, 8'h00, 0, 0, 0, 4,  4));
    // period 2, width 1, continuous, then stop
    vecs.push_back(mk("p2_start",  1, 0,  2, 1, 0, 8'h00, 1, 0, 0, 0, -1));
    vecs.push_back(mk("p2_w0",     0, 0,  2, 1, 0, 8'h55, 1, 0, 0, 4, -1));
    vecs.push_back(mk("p2_w1",     0, 0,  2, 1, 0, 8'h55, 1, 0, 0, 8, -1));
    vecs.push_back(mk("p2_w2",     0, 0,  2, 1, 0, 8'h55, 1, 0, 0, 12, -1));
    vecs.push_back(mk("p2_stop",   0, 1,  2, 1, 0, 8'h00, 0, 0, 1, 12, 12));
    vecs.push_back(mk("p2_idle",   0, 0,  2, 1, 0, 8'h00, 0, 0, 0, 12, -1));
    vecs.push_back(mk("p2_stopidl",0, 1,  2, 1, 0, 8'h00, 0, 0, 0, 12, -1));
    // period 1, width 0 clamps to period 2, width 1
    vecs.push_back(mk("p1_start",  1, 0,  1, 0, 0, 8'h00, 1, 0, 0, 0, -1));
    vecs.push_back(mk("p1_w0",     0, 0,  9, 9, 9, 8'h55, 1, 0, 0, 4, -1));
    vecs.push_back(mk("p1_w1",     0, 0,  9, 9, 9, 8'h55, 1, 0, 0, 8, -1));
    vecs.push_back(mk("p1_stop",   0, 1,  9, 9, 9, 8'h00, 0, 0, 1, 8, -1));
    // period 8, width 8 clamps to 7; restart attempt mid-run is ignored
    vecs.push_back(mk("p8_start",  1, 0,  8, 8, 0, 8'h00, 1, 0, 0, 0, -1));
    vecs.push_back(mk("p8_w0",     0, 0,  8, 8, 0, 8'h7F, 1, 0, 0, 1, -1));
    vecs.push_back(mk("p8_w1",     0, 0,  8, 8, 0, 8'h7F, 1, 0, 0, 2, -1));
    vecs.push_back(mk("p8_restart",1, 0,  2, 1, 0, 8'h7F, 1, 0, 0, 3, -1));
    vecs.push_back(mk("p8_w3",     0, 0,  2, 1, 0, 8'h7F, 1, 0, 0, 4, -1));
    vecs.push_back(mk("p8_stop",   0, 1,  2, 1, 0, 8'h00, 0, 0, 1, 4, -1));
    // start and stop together in IDLE: no run
    vecs.push_back(mk("ss_idle",   1, 1,  2, 1, 0, 8'h00, 0, 0, 0, 4, -1));
    vecs.push_back(mk("ss_after",  0, 0,  2, 1, 0, 8'h00, 0, 0, 0, 4, -1));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("reset", 8'h00, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("idle_after_reset", 8'h00, 0, 0, 0, 0);

    edges = 0;
    prev  = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].sp, vecs[i].per, vecs[i].wid, vecs[i].n);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].e_bits, vecs[i].e_busy, vecs[i].e_done,
            vecs[i].e_ab, vecs[i].e_nsent);
      if (vecs[i].st && !busy) begin
        // keep counting; starts are only meaningful when they launch a run
      end
      if (vecs[i].st && vecs[i].e_busy && vecs[i].e_nsent == 0) begin
        edges = 0;
        prev  = 1'b0;
      end
      w = bits_out;
      for (int b = 0; b < 8; b++) begin
        if (w[b] && !prev) edges++;
        prev = w[b];
      end
      if (vecs[i].e_edges >= 0) check_int({vecs[i].name, "_edges"}, edges, vecs[i].e_edges);
    end

    // n=1, period 100, width 20: one pulse, run ends at lane 100 (word 12)
    @(negedge clk);
    drive(1, 0, 100, 20, 1);
    @(posedge clk);
    #1 check("n1_start", 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      eb = (i < 2) ? 8'hFF : (i == 2) ? 8'h0F : 8'h00;
      if (i < 12) check($sformatf("n1_w%0d", i), eb, 1, 0, 0, 1);
      else        check("n1_done", eb, 0, 1, 0, 1);
    end
    @(posedge clk);
    #1 check("n1_after", 8'h00, 0, 0, 0, 1);

    // asynchronous reset mid-pulse, then a clean restart
    @(negedge clk);
    drive(1, 0, 10, 3, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("rr_w0", 8'h07, 1, 0, 0, 1);
    #2 rst = 1'b1;
    #1 check("rr_async", 8'h00, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("rr_idle", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 10, 3, 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("rr_w0b", 8'h07, 1, 0, 0, 1);
    @(posedge clk);
    #1 check("rr_w1b", 8'h1C, 1, 0, 0, 2);
    @(posedge clk);
    #1 check("rr_done", 8'h00, 0, 1, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
